// File: rtl/axi_conf.sv
// AXI4+ATOP channel and request/response struct types for the slave-side port.
package axi_conf;

  localparam int unsigned IdWidth   = 4;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned UserWidth = 1;

  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;
  typedef logic [UserWidth-1:0] user_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    user_t      user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_slv_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } resp_slv_t;

endpackage

// File: rtl/axi_pmp_pkg.sv
// State encodings and default response constants for the PMP error subordinate.
package axi_pmp_pkg;

  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP, W_ATOP} w_state_e;
  typedef enum logic       {R_IDLE, R_SEND} r_state_e;

  localparam logic [1:0]  RESP_SLVERR       = 2'b10;
  localparam logic [1:0]  RESP_DECERR       = 2'b11;
  localparam logic [63:0] DEFAULT_RESP_DATA = 64'hBADC_AB1E_BADC_AB1E;

  localparam int unsigned DataReps = (axi_conf::DataWidth + 63) / 64;

  // Replicate the 64-bit pattern across the bus, truncating any excess.
  function automatic axi_conf::data_t fill_data(input logic [63:0] pattern);
    logic [DataReps*64-1:0] rep;
    rep = {DataReps{pattern}};
    return rep[axi_conf::DataWidth-1:0];
  endfunction

endpackage

// File: rtl/axi_pmp_err_slv.sv
// Terminates every AXI4+ATOP transaction with an error response.
// Writes are drained and answered on B; atomics additionally get an R burst.
module axi_pmp_err_slv
  import axi_pmp_pkg::*;
#(
  parameter logic [1:0]  RespCode = RESP_SLVERR,
  parameter logic [63:0] RespData = DEFAULT_RESP_DATA,
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  axi_conf::req_slv_t  slv_req_i,
  output axi_conf::resp_slv_t slv_resp_o,
  output logic [CntWidth-1:0] err_cnt_o,
  output logic                busy_o
);

  w_state_e          w_state_q;
  axi_conf::id_t     w_id_q;
  logic [7:0]        w_len_q;
  logic              w_atop_q;
  axi_conf::b_chan_t b_q;

  r_state_e          r_state_q;
  logic [7:0]        r_cnt_q;
  logic [7:0]        r_len_q;
  axi_conf::r_chan_t r_q;

  logic [CntWidth-1:0] err_cnt_q, err_cnt_d;
  logic [CntWidth:0]   cnt_sum;

  logic          ar_ready;
  logic          ar_hs;
  logic          atop_handover;
  axi_conf::id_t start_id;
  logic [7:0]    start_len;
  logic          w_done;
  logic          r_done;
  logic          unused_req;

  // Atomic responses own the read path whenever the write side is waiting to hand over.
  assign ar_ready      = (r_state_q == R_IDLE) && (w_state_q != W_ATOP);
  assign ar_hs         = ar_ready && slv_req_i.ar_valid;
  assign atop_handover = (r_state_q == R_IDLE) && (w_state_q == W_ATOP);
  assign start_id      = atop_handover ? w_id_q  : slv_req_i.ar.id;
  assign start_len     = atop_handover ? w_len_q : slv_req_i.ar.len;

  assign w_done = (w_state_q == W_RESP) && slv_req_i.b_ready && !w_atop_q;
  assign r_done = (r_state_q == R_SEND) && slv_req_i.r_ready && r_q.last;

  // Address, attributes and write data are ignored by design.
  assign unused_req = ^slv_req_i;

  // Write FSM: accept AW, drain W until last, answer on B, hand atomics to the read side.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_atop_q  <= 1'b0;
      b_q       <= '0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          if (slv_req_i.aw_valid) begin
            w_id_q    <= slv_req_i.aw.id;
            w_len_q   <= slv_req_i.aw.len;
            w_atop_q  <= slv_req_i.aw.atop[5];
            w_state_q <= W_DRAIN;
          end
        end
        W_DRAIN: begin
          if (slv_req_i.w_valid && slv_req_i.w.last) begin
            b_q.id    <= w_id_q;
            b_q.resp  <= RespCode;
            b_q.user  <= '0;
            w_state_q <= W_RESP;
          end
        end
        W_RESP: begin
          if (slv_req_i.b_ready) begin
            w_state_q <= w_atop_q ? W_ATOP : W_IDLE;
          end
        end
        W_ATOP: begin
          if (r_state_q == R_IDLE) begin
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: stream len+1 error beats for an AR or a handed-over atomic.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      r_cnt_q   <= '0;
      r_len_q   <= '0;
      r_q       <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          if (atop_handover || ar_hs) begin
            r_len_q   <= start_len;
            r_cnt_q   <= '0;
            r_q.id    <= start_id;
            r_q.data  <= fill_data(RespData);
            r_q.resp  <= RespCode;
            r_q.last  <= (start_len == 8'd0);
            r_q.user  <= '0;
            r_state_q <= R_SEND;
          end
        end
        R_SEND: begin
          if (slv_req_i.r_ready) begin
            if (r_q.last) begin
              r_state_q <= R_IDLE;
            end else begin
              r_cnt_q  <= r_cnt_q + 8'd1;
              r_q.last <= ((r_cnt_q + 8'd1) == r_len_q);
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Both FSMs may finish in the same cycle, so the counter can step by two.
  always_comb begin
    cnt_sum   = {1'b0, err_cnt_q} + {{CntWidth{1'b0}}, w_done} + {{CntWidth{1'b0}}, r_done};
    err_cnt_d = cnt_sum[CntWidth] ? '1 : cnt_sum[CntWidth-1:0];
  end

  // Completed error transaction counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  // Ready/valid are pure state decodes; payloads come straight from registers.
  always_comb begin
    slv_resp_o          = '0;
    slv_resp_o.aw_ready = (w_state_q == W_IDLE);
    slv_resp_o.w_ready  = (w_state_q == W_DRAIN);
    slv_resp_o.b_valid  = (w_state_q == W_RESP);
    slv_resp_o.b        = b_q;
    slv_resp_o.ar_ready = ar_ready;
    slv_resp_o.r_valid  = (r_state_q == R_SEND);
    slv_resp_o.r        = r_q;
  end

  assign err_cnt_o = err_cnt_q;
  assign busy_o    = (w_state_q != W_IDLE) || (r_state_q != R_IDLE);

endmodule

// File: tb/tb_axi_pmp_err_slv.sv
// Self-checking bench for axi_pmp_err_slv: directed scenarios plus randomized
// read/write traffic compared against a transaction-level expectation.
module tb_axi_pmp_err_slv;
  import axi_conf::*;

  localparam logic [63:0] EXP_DATA = 64'hBADC_AB1E_BADC_AB1E;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  req_slv_t  req;
  resp_slv_t resp, resp_sat;
  logic [31:0] err_cnt;
  logic [1:0]  err_cnt_sat;
  logic busy, busy_sat;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  axi_pmp_err_slv #(.RespCode(2'b10), .RespData(EXP_DATA), .CntWidth(32)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .slv_req_i(req), .slv_resp_o(resp),
    .err_cnt_o(err_cnt), .busy_o(busy));

  axi_pmp_err_slv #(.RespCode(2'b11), .RespData(EXP_DATA), .CntWidth(2)) u_sat (
    .clk_i(clk), .rst_ni(rst_ni), .slv_req_i(req), .slv_resp_o(resp_sat),
    .err_cnt_o(err_cnt_sat), .busy_o(busy_sat));

  task automatic cyc();
    @(negedge clk);
  endtask

  function automatic logic [71:0] r_exp(input logic [3:0] id, input logic last);
    return {1'b1, id, 2'b10, last, EXP_DATA};
  endfunction

  function automatic logic [71:0] r_obs();
    return {resp.r_valid, resp.r.id, resp.r.resp, resp.r.last, resp.r.data};
  endfunction

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic test_reset();
    req = '0;
    rst_ni = 1'b0;
    cyc();
    n_tests++;
    if ({resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid} !== 5'b11000) begin
      n_fail++;
      $display("FAIL reset_handshake: got %b want 11000",
               {resp.aw_ready, resp.ar_ready, resp.w_ready, resp.b_valid, resp.r_valid});
    end
    n_tests++;
    if (resp.b !== '0 || resp.r !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: got b=%h r=%h want 0", resp.b, resp.r);
    end
    n_tests++;
    if (err_cnt !== 32'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cnt_busy: got cnt=%0d busy=%b want 0/0", err_cnt, busy);
    end
    rst_ni = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_read_burst();
    cyc();
    req.ar_valid = 1'b1; req.ar.id = 4'd3; req.ar.len = 8'd3; req.r_ready = 1'b1;
    n_tests++;
    if (resp.ar_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd_ar_ready: got %b want 1", resp.ar_ready);
    end
    cyc();
    req.ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (r_obs() !== r_exp(4'd3, i == 3)) begin
        n_fail++; $display("FAIL rd_beat%0d: got %h want %h", i, r_obs(), r_exp(4'd3, i == 3));
      end
      cyc();
    end
    req.r_ready = 1'b0;
    exp_cnt++;
    n_tests++;
    if (resp.r_valid !== 1'b0 || err_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL rd_done: got valid=%b cnt=%0d want 0/%0d", resp.r_valid, err_cnt, exp_cnt);
    end
    n_tests++;
    if (resp_sat.r.resp !== 2'b11 || err_cnt_sat !== 2'(sat3(exp_cnt))) begin
      n_fail++; $display("FAIL rd_decerr_inst: got resp=%b cnt=%0d want 11/%0d",
                         resp_sat.r.resp, err_cnt_sat, sat3(exp_cnt));
    end
  endtask

  task automatic test_write_b_stall();
    cyc();
    req.aw_valid = 1'b1; req.aw.id = 4'd5; req.aw.len = 8'd1; req.aw.atop = 6'd0;
    req.w_valid = 1'b0; req.b_ready = 1'b0;
    cyc();
    req.aw_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req.w_valid = 1'b1; req.w.last = (i == 1); req.w.data = {$urandom, $urandom};
      n_tests++;
      if (resp.w_ready !== 1'b1) begin
        n_fail++; $display("FAIL wr_w_ready%0d: got %b want 1", i, resp.w_ready);
      end
      cyc();
    end
    req.w_valid = 1'b0; req.w.last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if ({resp.b_valid, resp.b.id, resp.b.resp, resp.b.user} !== {1'b1, 4'd5, 2'b10, 1'b0}
          || err_cnt !== 32'(exp_cnt)) begin
        n_fail++; $display("FAIL wr_b_hold%0d: got v=%b id=%0d resp=%b cnt=%0d want 1/5/10/%0d",
                           k, resp.b_valid, resp.b.id, resp.b.resp, err_cnt, exp_cnt);
      end
      if (k == 3) req.b_ready = 1'b1;
      cyc();
    end
    req.b_ready = 1'b0;
    exp_cnt++;
    n_tests++;
    if (resp.b_valid !== 1'b0 || err_cnt !== 32'(exp_cnt) || busy !== 1'b0) begin
      n_fail++; $display("FAIL wr_done: got v=%b cnt=%0d busy=%b want 0/%0d/0",
                         resp.b_valid, err_cnt, busy, exp_cnt);
    end
  endtask

  task automatic test_w_before_aw();
    cyc();
    req.w_valid = 1'b1; req.w.last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++;
      if (resp.w_ready !== 1'b0) begin
        n_fail++; $display("FAIL wpre_held%0d: got w_ready=%b want 0", i, resp.w_ready);
      end
    end
    req.aw_valid = 1'b1; req.aw.id = 4'hA; req.aw.len = 8'd1; req.aw.atop = 6'd0;
    cyc();
    req.aw_valid = 1'b0;
    n_tests++;
    if (resp.w_ready !== 1'b1) begin
      n_fail++; $display("FAIL wpre_drain0: got %b want 1", resp.w_ready);
    end
    cyc();
    req.w.last = 1'b1;
    n_tests++;
    if (resp.w_ready !== 1'b1 || resp.b_valid !== 1'b0) begin
      n_fail++; $display("FAIL wpre_drain1: got w_ready=%b b_valid=%b want 1/0", resp.w_ready, resp.b_valid);
    end
    cyc();
    req.w_valid = 1'b0; req.w.last = 1'b0; req.b_ready = 1'b1;
    n_tests++;
    if (resp.b_valid !== 1'b1 || resp.b.id !== 4'hA) begin
      n_fail++; $display("FAIL wpre_b: got v=%b id=%h want 1/a", resp.b_valid, resp.b.id);
    end
    cyc();
    req.b_ready = 1'b0;
    exp_cnt++;
    n_tests++;
    if (err_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL wpre_cnt: got %0d want %0d", err_cnt, exp_cnt);
    end
  endtask

  task automatic test_atomic();
    logic [3:0] got_id [5];
    logic       got_last [5];
    logic [1:0] got_resp [5];
    int nb, ar_hi;
    cyc();
    req.ar_valid = 1'b1; req.ar.id = 4'd2; req.ar.len = 8'd3; req.r_ready = 1'b0;
    req.aw_valid = 1'b1; req.aw.id = 4'd7; req.aw.len = 8'd0; req.aw.atop = 6'b100000;
    req.w_valid = 1'b1; req.w.last = 1'b1; req.b_ready = 1'b1;
    cyc();
    req.ar_valid = 1'b0; req.aw_valid = 1'b0;
    cyc();
    req.w_valid = 1'b0; req.w.last = 1'b0;
    n_tests++;
    if (resp.b_valid !== 1'b1 || resp.b.id !== 4'd7) begin
      n_fail++; $display("FAIL atop_b: got v=%b id=%0d want 1/7", resp.b_valid, resp.b.id);
    end
    cyc();
    req.b_ready = 1'b0;
    n_tests++;
    if (resp.ar_ready !== 1'b0 || busy !== 1'b1 || err_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL atop_wait: got ar_ready=%b busy=%b cnt=%0d want 0/1/%0d",
                         resp.ar_ready, busy, err_cnt, exp_cnt);
    end
    req.r_ready = 1'b1;
    nb = 0; ar_hi = 0;
    for (int t = 0; t < 40 && nb < 5; t++) begin
      if (resp.ar_ready) ar_hi++;
      if (resp.r_valid) begin
        got_id[nb] = resp.r.id; got_last[nb] = resp.r.last; got_resp[nb] = resp.r.resp;
        nb++;
      end
      cyc();
    end
    req.r_ready = 1'b0;
    n_tests++;
    if (nb != 5) begin
      n_fail++; $display("FAIL atop_beats: got %0d beats want 5 (timeout)", nb);
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_tests++;
        if ({got_id[k], got_last[k], got_resp[k]} !== {((k < 4) ? 4'd2 : 4'd7), (k >= 3), 2'b10}) begin
          n_fail++; $display("FAIL atop_order%0d: got id=%0d last=%b resp=%b want %0d/%b/10",
                             k, got_id[k], got_last[k], got_resp[k], (k < 4) ? 2 : 7, k >= 3);
        end
      end
    end
    n_tests++;
    if (ar_hi != 0) begin
      n_fail++; $display("FAIL atop_ar_block: got %0d ar_ready cycles want 0", ar_hi);
    end
    exp_cnt += 2;
    n_tests++;
    if (err_cnt !== 32'(exp_cnt) || resp.ar_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL atop_done: got cnt=%0d ar_ready=%b busy=%b want %0d/1/0",
                         err_cnt, resp.ar_ready, busy, exp_cnt);
    end
  endtask

  task automatic test_concurrent();
    cyc();
    req.aw_valid = 1'b1; req.aw.id = 4'd1; req.aw.len = 8'd0; req.aw.atop = 6'd0;
    req.ar_valid = 1'b1; req.ar.id = 4'd9; req.ar.len = 8'd1;
    req.w_valid = 1'b1; req.w.last = 1'b1; req.b_ready = 1'b0; req.r_ready = 1'b1;
    n_tests++;
    if ({resp.aw_ready, resp.ar_ready} !== 2'b11) begin
      n_fail++; $display("FAIL conc_ready: got %b want 11", {resp.aw_ready, resp.ar_ready});
    end
    cyc();
    req.aw_valid = 1'b0; req.ar_valid = 1'b0;
    n_tests++;
    if (r_obs() !== r_exp(4'd9, 1'b0) || resp.w_ready !== 1'b1) begin
      n_fail++; $display("FAIL conc_first: got r=%h w_ready=%b want %h/1", r_obs(), resp.w_ready, r_exp(4'd9, 1'b0));
    end
    cyc();
    req.w_valid = 1'b0; req.w.last = 1'b0; req.b_ready = 1'b1;
    n_tests++;
    if (r_obs() !== r_exp(4'd9, 1'b1) || resp.b_valid !== 1'b1 || resp.b.id !== 4'd1
        || err_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL conc_both: got r=%h b_valid=%b b_id=%0d cnt=%0d want %h/1/1/%0d",
                         r_obs(), resp.b_valid, resp.b.id, err_cnt, r_exp(4'd9, 1'b1), exp_cnt);
    end
    cyc();
    req.b_ready = 1'b0; req.r_ready = 1'b0;
    exp_cnt += 2;
    n_tests++;
    if (err_cnt !== 32'(exp_cnt) || resp.b_valid !== 1'b0 || resp.r_valid !== 1'b0) begin
      n_fail++; $display("FAIL conc_cnt2: got cnt=%0d b=%b r=%b want %0d/0/0",
                         err_cnt, resp.b_valid, resp.r_valid, exp_cnt);
    end
  endtask

  task automatic test_long_burst();
    int beats;
    logic done;
    cyc();
    req.ar_valid = 1'b1; req.ar.id = 4'hC; req.ar.len = 8'd255; req.r_ready = 1'b1;
    cyc();
    req.ar_valid = 1'b0;
    beats = 0; done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      if (resp.r_valid) begin
        beats++;
        n_tests++;
        if (resp.r.id !== 4'hC || resp.r.last !== (beats == 256)) begin
          n_fail++; $display("FAIL long_beat%0d: got id=%h last=%b want c/%b", beats, resp.r.id, resp.r.last, beats == 256);
        end
        if (resp.r.last) done = 1'b1;
      end
      cyc();
    end
    req.r_ready = 1'b0;
    exp_cnt++;
    n_tests++;
    if (beats != 256 || err_cnt !== 32'(exp_cnt) || resp.r_valid !== 1'b0) begin
      n_fail++; $display("FAIL long_total: got beats=%0d cnt=%0d valid=%b want 256/%0d/0",
                         beats, err_cnt, resp.r_valid, exp_cnt);
    end
  endtask

  task automatic test_random();
    logic [3:0]  id;
    logic [7:0]  len;
    logic        is_wr, rr, done, pend;
    logic [71:0] prev;
    int beat;
    for (int it = 0; it < 30; it++) begin
      id = 4'($urandom_range(0, 15));
      len = 8'($urandom_range(0, 12));
      is_wr = 1'($urandom_range(0, 1));
      done = 1'b0; pend = 1'b0; beat = 0; prev = '0;
      cyc();
      if (!is_wr) begin
        req.ar_valid = 1'b1; req.ar.id = id; req.ar.len = len; req.r_ready = 1'b0;
        cyc();
        req.ar_valid = 1'b0;
        n_tests++;
        if (resp.r_valid !== 1'b1) begin
          n_fail++; $display("FAIL rnd_rd_latency it%0d: got %b want 1", it, resp.r_valid);
        end
        for (int t = 0; t < 200 && !done; t++) begin
          if (pend) begin
            n_tests++;
            if (r_obs() !== prev) begin
              n_fail++; $display("FAIL rnd_rd_stable it%0d: got %h want %h", it, r_obs(), prev);
            end
          end
          rr = ($urandom_range(0, 2) != 0);
          req.r_ready = rr;
          if (resp.r_valid && rr) begin
            n_tests++;
            if (r_obs() !== r_exp(id, beat == int'(len))) begin
              n_fail++; $display("FAIL rnd_rd_beat it%0d b%0d: got %h want %h", it, beat, r_obs(), r_exp(id, beat == int'(len)));
            end
            beat++;
            pend = 1'b0;
            if (beat > int'(len)) done = 1'b1;
          end else begin
            pend = resp.r_valid;
            prev = r_obs();
          end
          cyc();
        end
        req.r_ready = 1'b0;
      end else begin
        req.aw_valid = 1'b1; req.aw.id = id; req.aw.len = len; req.aw.atop = 6'd0;
        req.b_ready = 1'b0;
        cyc();
        req.aw_valid = 1'b0;
        for (int t = 0; t < 200 && beat <= int'(len); t++) begin
          req.w_valid = ($urandom_range(0, 2) != 0);
          req.w.last = (beat == int'(len));
          req.w.data = {$urandom, $urandom};
          if (req.w_valid && resp.w_ready) beat++;
          cyc();
        end
        req.w_valid = 1'b0; req.w.last = 1'b0;
        n_tests++;
        if (resp.b_valid !== 1'b1 || resp.b.id !== id) begin
          n_fail++; $display("FAIL rnd_wr_b it%0d: got v=%b id=%h want 1/%h", it, resp.b_valid, resp.b.id, id);
        end
        for (int t = 0; t < 50 && !done; t++) begin
          rr = ($urandom_range(0, 2) == 0);
          req.b_ready = rr;
          n_tests++;
          if ({resp.b_valid, resp.b.id, resp.b.resp} !== {1'b1, id, 2'b10}) begin
            n_fail++; $display("FAIL rnd_wr_bhold it%0d: got v=%b id=%h resp=%b want 1/%h/10",
                               it, resp.b_valid, resp.b.id, resp.b.resp, id);
          end
          if (rr) done = 1'b1;
          cyc();
        end
        req.b_ready = 1'b0;
      end
      n_tests++;
      if (!done) begin
        n_fail++; $display("FAIL rnd_timeout it%0d: got no completion want completion", it);
      end
      exp_cnt++;
      n_tests++;
      if (err_cnt !== 32'(exp_cnt) || busy !== 1'b0) begin
        n_fail++; $display("FAIL rnd_cnt it%0d: got cnt=%0d busy=%b want %0d/0", it, err_cnt, busy, exp_cnt);
      end
    end
    n_tests++;
    if (err_cnt_sat !== 2'(sat3(exp_cnt))) begin
      n_fail++; $display("FAIL rnd_saturate: got %0d want %0d", err_cnt_sat, sat3(exp_cnt));
    end
  endtask

  task automatic test_reset_mid_burst();
    cyc();
    req.ar_valid = 1'b1; req.ar.id = 4'd4; req.ar.len = 8'd7; req.r_ready = 1'b1;
    cyc();
    req.ar_valid = 1'b0;
    cyc();
    n_tests++;
    if (r_obs() !== r_exp(4'd4, 1'b0)) begin
      n_fail++; $display("FAIL rstmid_beat2: got %h want %h", r_obs(), r_exp(4'd4, 1'b0));
    end
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    exp_cnt = 0;
    n_tests++;
    if ({resp.r_valid, resp.ar_ready, resp.aw_ready, busy} !== 4'b0110 || err_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rstmid_state: got r_valid=%b ar_ready=%b aw_ready=%b busy=%b cnt=%0d want 0/1/1/0/0",
                         resp.r_valid, resp.ar_ready, resp.aw_ready, busy, err_cnt);
    end
    cyc();
    n_tests++;
    if (resp.r_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_no_beats: got r_valid=%b want 0", resp.r_valid);
    end
    req.ar_valid = 1'b1; req.ar.id = 4'd6; req.ar.len = 8'd1;
    cyc();
    req.ar_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (r_obs() !== r_exp(4'd6, i == 1)) begin
        n_fail++; $display("FAIL rstmid_new%0d: got %h want %h", i, r_obs(), r_exp(4'd6, i == 1));
      end
      cyc();
    end
    req.r_ready = 1'b0;
    exp_cnt++;
    n_tests++;
    if (err_cnt !== 32'(exp_cnt) || resp.r_valid !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_cnt: got cnt=%0d valid=%b want %0d/0", err_cnt, resp.r_valid, exp_cnt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0;
    test_reset();
    test_read_burst();
    test_write_b_stall();
    test_w_before_aw();
    test_atomic();
    test_concurrent();
    test_long_burst();
    test_random();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
